// File: rtl/spu_ibr_mtx_ctl.sv
// spu_ibr_mtx_ctl: inbound-response controller for the SPU. Tracks up to
// NUM_SLOT outstanding requests by TID, checks head/data response flits
// against each slot, applies a programmable idle timeout per slot, and
// retires completed slots lowest-index first through a valid/ready port.
module spu_ibr_mtx_ctl #(
  parameter int unsigned TID_W      = 8,
  parameter int unsigned TILE_ID_W  = 6,
  parameter int unsigned NUM_SLOT   = 4,
  parameter int unsigned FLIT_CNT_W = 4,
  parameter int unsigned TO_W       = 20
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            req_vld,
  output logic                            req_rdy,
  input  logic [TID_W-1:0]                req_tid,
  input  logic [FLIT_CNT_W-1:0]           req_flits,
  input  logic [TILE_ID_W-1:0]            local_tile_id,
  input  logic [TO_W-1:0]                 cfg_rsp_timeout,
  input  logic                            ib_rsp_vld,
  output logic                            ib_rsp_rdy,
  input  logic [1:0]                      ib_rsp_type,
  input  logic [TID_W-1:0]                ib_rsp_tid,
  input  logic [TILE_ID_W-1:0]            ib_rsp_dst_tile_id,
  input  logic                            ib_rsp_status,
  output logic                            res_vld,
  input  logic                            res_rdy,
  output logic [TID_W-1:0]                res_tid,
  output logic [2:0]                      res_code,
  output logic                            unmatched_pulse,
  output logic                            tile_mismatch_pulse,
  output logic [$clog2(NUM_SLOT+1)-1:0]   active_cnt
);

  localparam int unsigned CNT_W = $clog2(NUM_SLOT + 1);

  localparam logic [1:0] RSP_HEAD       = 2'd0;
  localparam logic [1:0] RSP_DATA       = 2'd1;
  localparam logic       RSP_STATUS_ERR = 1'b1;

  localparam logic [2:0] CODE_OK      = 3'd0;
  localparam logic [2:0] CODE_STS_ERR = 3'd1;
  localparam logic [2:0] CODE_HEAD_TO = 3'd2;
  localparam logic [2:0] CODE_DATA_TO = 3'd3;
  localparam logic [2:0] CODE_SEQ_ERR = 3'd4;

  typedef enum logic [1:0] {
    S_FREE      = 2'd0,
    S_WAIT_HEAD = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_DONE      = 2'd3
  } slot_st_e;

  // Per-slot registered state
  slot_st_e [NUM_SLOT-1:0]                 st_q, st_d;
  logic     [NUM_SLOT-1:0][TID_W-1:0]      tid_q, tid_d;
  logic     [NUM_SLOT-1:0][FLIT_CNT_W-1:0] rem_q, rem_d;
  logic     [NUM_SLOT-1:0][TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic     [NUM_SLOT-1:0][2:0]            code_q, code_d;

  // Control flops
  logic rdy_q, rdy_d;
  logic unmatched_pulse_q, unmatched_pulse_d;
  logic tile_mismatch_pulse_q, tile_mismatch_pulse_d;

  // Derived per-slot status
  logic [NUM_SLOT-1:0] free_vec;
  logic [NUM_SLOT-1:0] done_vec;
  logic [NUM_SLOT-1:0] free_lo;
  logic [NUM_SLOT-1:0] done_lo;
  logic [NUM_SLOT-1:0] rsp_match;
  logic [NUM_SLOT-1:0] rsp_hit;
  logic [NUM_SLOT-1:0] to_hit;
  logic                req_tid_busy;
  logic                alloc_fire;
  logic                rsp_acc;
  logic                tile_ok;
  logic                type_ok;
  logic                res_fire;

  // Slot occupancy, TID lookups and timeout conditions from current state
  always_comb begin
    free_vec     = '0;
    done_vec     = '0;
    rsp_match    = '0;
    to_hit       = '0;
    req_tid_busy = 1'b0;
    for (int i = 0; i < int'(NUM_SLOT); i++) begin
      free_vec[i]  = (st_q[i] == S_FREE);
      done_vec[i]  = (st_q[i] == S_DONE);
      rsp_match[i] = (st_q[i] != S_FREE) && (tid_q[i] == ib_rsp_tid);
      to_hit[i]    = (cfg_rsp_timeout != '0) && (to_cnt_q[i] == cfg_rsp_timeout);
      if ((st_q[i] != S_FREE) && (tid_q[i] == req_tid)) begin
        req_tid_busy = 1'b1;
      end
    end
  end

  // Lowest-index selection isolates the least significant set bit
  assign free_lo = free_vec & (~free_vec + NUM_SLOT'(1));
  assign done_lo = done_vec & (~done_vec + NUM_SLOT'(1));

  assign req_rdy    = rdy_q && (|free_vec) && !req_tid_busy;
  assign alloc_fire = req_vld && req_rdy;

  assign ib_rsp_rdy = rdy_q;
  assign rsp_acc    = ib_rsp_vld && rdy_q;
  assign tile_ok    = (ib_rsp_dst_tile_id == local_tile_id);
  assign type_ok    = (ib_rsp_type == RSP_HEAD) || (ib_rsp_type == RSP_DATA);
  assign rsp_hit    = (rsp_acc && tile_ok && type_ok) ? rsp_match : '0;

  assign res_vld  = |done_vec;
  assign res_fire = res_vld && res_rdy;

  // Result payload from the lowest-index DONE slot
  always_comb begin
    res_tid  = '0;
    res_code = '0;
    for (int i = 0; i < int'(NUM_SLOT); i++) begin
      if (done_lo[i]) begin
        res_tid  = tid_q[i];
        res_code = code_q[i];
      end
    end
  end

  // Count of occupied slots
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < int'(NUM_SLOT); i++) begin
      if (!free_vec[i]) begin
        active_cnt = active_cnt + CNT_W'(1);
      end
    end
  end

  // Per-slot next state: allocation, flit handling, timeout, retire
  always_comb begin
    st_d     = st_q;
    tid_d    = tid_q;
    rem_d    = rem_q;
    to_cnt_d = to_cnt_q;
    code_d   = code_q;
    for (int i = 0; i < int'(NUM_SLOT); i++) begin
      case (st_q[i])
        S_FREE: begin
          if (alloc_fire && free_lo[i]) begin
            st_d[i]     = S_WAIT_HEAD;
            tid_d[i]    = req_tid;
            rem_d[i]    = req_flits;
            to_cnt_d[i] = '0;
            code_d[i]   = CODE_OK;
          end
        end
        S_WAIT_HEAD: begin
          if (to_cnt_q[i] != '1) begin
            to_cnt_d[i] = to_cnt_q[i] + TO_W'(1);
          end
          if (rsp_hit[i]) begin
            if (ib_rsp_type != RSP_HEAD) begin
              st_d[i]   = S_DONE;
              code_d[i] = CODE_SEQ_ERR;
            end else if (ib_rsp_status == RSP_STATUS_ERR) begin
              st_d[i]   = S_DONE;
              code_d[i] = CODE_STS_ERR;
            end else if (rem_q[i] == '0) begin
              st_d[i]   = S_DONE;
              code_d[i] = CODE_OK;
            end else begin
              st_d[i]     = S_WAIT_DATA;
              to_cnt_d[i] = '0;
            end
          end else if (to_hit[i]) begin
            st_d[i]   = S_DONE;
            code_d[i] = CODE_HEAD_TO;
          end
        end
        S_WAIT_DATA: begin
          if (to_cnt_q[i] != '1) begin
            to_cnt_d[i] = to_cnt_q[i] + TO_W'(1);
          end
          if (rsp_hit[i]) begin
            if (ib_rsp_type != RSP_DATA) begin
              st_d[i]   = S_DONE;
              code_d[i] = CODE_SEQ_ERR;
            end else if (ib_rsp_status == RSP_STATUS_ERR) begin
              st_d[i]   = S_DONE;
              code_d[i] = CODE_STS_ERR;
            end else if (rem_q[i] == FLIT_CNT_W'(1)) begin
              st_d[i]   = S_DONE;
              code_d[i] = CODE_OK;
            end else begin
              rem_d[i]    = rem_q[i] - FLIT_CNT_W'(1);
              to_cnt_d[i] = '0;
            end
          end else if (to_hit[i]) begin
            st_d[i]   = S_DONE;
            code_d[i] = CODE_DATA_TO;
          end
        end
        S_DONE: begin
          if (res_fire && done_lo[i]) begin
            st_d[i] = S_FREE;
          end
        end
        default: begin
          st_d[i] = S_FREE;
        end
      endcase
    end
  end

  // Ready enable and error pulses for the next cycle
  always_comb begin
    rdy_d                 = 1'b1;
    unmatched_pulse_d     = rsp_acc && tile_ok && (!type_ok || !(|rsp_match));
    tile_mismatch_pulse_d = rsp_acc && !tile_ok;
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q                  <= {NUM_SLOT{S_FREE}};
      tid_q                 <= '0;
      rem_q                 <= '0;
      to_cnt_q              <= '0;
      code_q                <= '0;
      rdy_q                 <= 1'b0;
      unmatched_pulse_q     <= 1'b0;
      tile_mismatch_pulse_q <= 1'b0;
    end else begin
      st_q                  <= st_d;
      tid_q                 <= tid_d;
      rem_q                 <= rem_d;
      to_cnt_q              <= to_cnt_d;
      code_q                <= code_d;
      rdy_q                 <= rdy_d;
      unmatched_pulse_q     <= unmatched_pulse_d;
      tile_mismatch_pulse_q <= tile_mismatch_pulse_d;
    end
  end

  assign unmatched_pulse     = unmatched_pulse_q;
  assign tile_mismatch_pulse = tile_mismatch_pulse_q;

endmodule
